control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_control_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with retire pulse.
// Outputs are decoded from the registered state plus opcode, mem_ready and zero; reset is async active-high.
// Optional macro ILLEGAL_TRAP_EN: opcodes 18-31 enter a TRAP state (illegal=1) instead of acting as NOP.
module control_fsm #(
  parameter int WIDTH_OPCODE = 5,  // only 5 is supported
  parameter int ALUOP_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH_OPCODE-1:0] opcode,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_src,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    iord,
  output logic                    reg_write,
  output logic                    alu_src_b,
  output logic [ALUOP_WIDTH-1:0]  alu_op,
  output logic                    wb_sel,
  output logic [2:0]              state,
  output logic                    retired,
  output logic                    illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  // Opcode map
  localparam logic [WIDTH_OPCODE-1:0] OP_NOP  = WIDTH_OPCODE'(0);
  localparam logic [WIDTH_OPCODE-1:0] OP_LR   = WIDTH_OPCODE'(1);
  localparam logic [WIDTH_OPCODE-1:0] OP_SR   = WIDTH_OPCODE'(2);
  localparam logic [WIDTH_OPCODE-1:0] OP_ADD  = WIDTH_OPCODE'(3);
  localparam logic [WIDTH_OPCODE-1:0] OP_ADDI = WIDTH_OPCODE'(4);
  localparam logic [WIDTH_OPCODE-1:0] OP_SUB  = WIDTH_OPCODE'(5);
  localparam logic [WIDTH_OPCODE-1:0] OP_MOV  = WIDTH_OPCODE'(6);
  localparam logic [WIDTH_OPCODE-1:0] OP_INC  = WIDTH_OPCODE'(7);
  localparam logic [WIDTH_OPCODE-1:0] OP_LI   = WIDTH_OPCODE'(8);
  localparam logic [WIDTH_OPCODE-1:0] OP_BEQ  = WIDTH_OPCODE'(9);
  localparam logic [WIDTH_OPCODE-1:0] OP_BNE  = WIDTH_OPCODE'(10);
  localparam logic [WIDTH_OPCODE-1:0] OP_JMP  = WIDTH_OPCODE'(11);
  localparam logic [WIDTH_OPCODE-1:0] OP_AND  = WIDTH_OPCODE'(12);
  localparam logic [WIDTH_OPCODE-1:0] OP_OR   = WIDTH_OPCODE'(13);
  localparam logic [WIDTH_OPCODE-1:0] OP_NOT  = WIDTH_OPCODE'(14);
  localparam logic [WIDTH_OPCODE-1:0] OP_XOR  = WIDTH_OPCODE'(15);
  localparam logic [WIDTH_OPCODE-1:0] OP_SHL  = WIDTH_OPCODE'(16);
  localparam logic [WIDTH_OPCODE-1:0] OP_SHR  = WIDTH_OPCODE'(17);

  // ALU function codes
  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD    = ALUOP_WIDTH'(0);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB    = ALUOP_WIDTH'(1);
  localparam logic [ALUOP_WIDTH-1:0] ALU_AND    = ALUOP_WIDTH'(2);
  localparam logic [ALUOP_WIDTH-1:0] ALU_OR     = ALUOP_WIDTH'(3);
  localparam logic [ALUOP_WIDTH-1:0] ALU_XOR    = ALUOP_WIDTH'(4);
  localparam logic [ALUOP_WIDTH-1:0] ALU_NOT    = ALUOP_WIDTH'(5);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SHL    = ALUOP_WIDTH'(6);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SHR    = ALUOP_WIDTH'(7);
  localparam logic [ALUOP_WIDTH-1:0] ALU_INCR   = ALUOP_WIDTH'(8);
  localparam logic [ALUOP_WIDTH-1:0] ALU_PASS_B = ALUOP_WIDTH'(9);
  localparam logic [ALUOP_WIDTH-1:0] ALU_PASS_A = ALUOP_WIDTH'(10);

  state_t cur;

  logic is_nop, is_lr, is_sr, is_alu, is_branch, is_illegal, br_taken;
  logic [ALUOP_WIDTH-1:0] exec_alu_op;
  logic                   exec_src_b;

  // Instruction class decode; opcode is stable from DECODE onward
  assign is_nop     = (opcode == OP_NOP);
  assign is_lr      = (opcode == OP_LR);
  assign is_sr      = (opcode == OP_SR);
  assign is_branch  = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_JMP);
  assign is_alu     = ((opcode >= OP_ADD) && (opcode <= OP_LI)) ||
                      ((opcode >= OP_AND) && (opcode <= OP_SHR));
  assign is_illegal = (opcode > OP_SHR);
  assign br_taken   = ((opcode == OP_BEQ) && zero) ||
                      ((opcode == OP_BNE) && !zero) ||
                      (opcode == OP_JMP);

  assign state = cur;

  // State register and transitions; reset abandons any memory access in flight
`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (cur)
        S_FETCH:  if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          if (is_lr || is_sr || is_alu || is_branch) begin
            cur <= S_EXEC;
          end else if (is_illegal) begin
            cur       <= S_TRAP;
            illegal_q <= 1'b1;
          end else begin
            cur <= S_FETCH;
          end
        end
        S_EXEC: begin
          if (is_lr || is_sr) cur <= S_MEM;
          else if (is_alu)    cur <= S_WB;
          else                cur <= S_FETCH;
        end
        S_MEM:    if (mem_ready) cur <= is_lr ? S_WB : S_FETCH;
        S_WB:     cur <= S_FETCH;
        S_TRAP:   cur <= S_TRAP;
        default:  cur <= S_FETCH;
      endcase
    end
  end
`else
  assign illegal = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:  if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          if (is_lr || is_sr || is_alu || is_branch) cur <= S_EXEC;
          else                                        cur <= S_FETCH;
        end
        S_EXEC: begin
          if (is_lr || is_sr) cur <= S_MEM;
          else if (is_alu)    cur <= S_WB;
          else                cur <= S_FETCH;
        end
        S_MEM:    if (mem_ready) cur <= is_lr ? S_WB : S_FETCH;
        S_WB:     cur <= S_FETCH;
        default:  cur <= S_FETCH;
      endcase
    end
  end
`endif

  // ALU function and operand-B select used during EXEC
  always_comb begin
    exec_alu_op = ALU_ADD;
    exec_src_b  = 1'b0;
    case (opcode)
      OP_LR, OP_SR: begin exec_alu_op = ALU_ADD;    exec_src_b = 1'b1; end
      OP_ADD:       begin exec_alu_op = ALU_ADD;    exec_src_b = 1'b0; end
      OP_ADDI:      begin exec_alu_op = ALU_ADD;    exec_src_b = 1'b1; end
      OP_SUB:       begin exec_alu_op = ALU_SUB;    exec_src_b = 1'b0; end
      OP_MOV:       begin exec_alu_op = ALU_PASS_A; exec_src_b = 1'b0; end
      OP_INC:       begin exec_alu_op = ALU_INCR;   exec_src_b = 1'b0; end
      OP_LI:        begin exec_alu_op = ALU_PASS_B; exec_src_b = 1'b1; end
      OP_BEQ, OP_BNE, OP_JMP:
                    begin exec_alu_op = ALU_SUB;    exec_src_b = 1'b0; end
      OP_AND:       begin exec_alu_op = ALU_AND;    exec_src_b = 1'b0; end
      OP_OR:        begin exec_alu_op = ALU_OR;     exec_src_b = 1'b0; end
      OP_NOT:       begin exec_alu_op = ALU_NOT;    exec_src_b = 1'b0; end
      OP_XOR:       begin exec_alu_op = ALU_XOR;    exec_src_b = 1'b0; end
      OP_SHL:       begin exec_alu_op = ALU_SHL;    exec_src_b = 1'b1; end
      OP_SHR:       begin exec_alu_op = ALU_SHR;    exec_src_b = 1'b1; end
      default:      begin exec_alu_op = ALU_ADD;    exec_src_b = 1'b0; end
    endcase
  end

  // Control outputs per state; anything not asserted for a state stays 0
  always_comb begin
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    reg_write = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    wb_sel    = 1'b0;
    retired   = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        retired = is_nop;
`else
        retired = is_nop || is_illegal;
`endif
      end
      S_EXEC: begin
        alu_op    = exec_alu_op;
        alu_src_b = exec_src_b;
        if (is_branch) begin
          pc_write = br_taken;
          pc_src   = br_taken;
          retired  = 1'b1;
        end
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = is_lr;
        mem_write = is_sr;
        retired   = is_sr && mem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_lr;
        retired   = 1'b1;
      end
      default: begin
        retired = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed stimulus for control_fsm with a queue-based scoreboard checking every stimulated cycle.
// Expected output vectors are hand-derived constants pushed by the stimulus thread.
// A monitor thread pops and compares one vector per cycle on the falling edge.
module tb_control_fsm;

  typedef struct packed {
    logic [2:0] st;
    logic       ir, pw, ps, mr, mw, io, rw, sb;
    logic [3:0] aop;
    logic       wb, ret, ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       ir_write, pc_write, pc_src, mem_read, mem_write, iord, reg_write, alu_src_b;
  logic [3:0] alu_op;
  logic       wb_sel;
  logic [2:0] state;
  logic       retired, illegal;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  // {opcode, alu_op, alu_src_b}
  int alu_tab [0:11][0:2] = '{
    '{3, 0, 0}, '{4, 0, 1}, '{5, 1, 0}, '{6, 10, 0}, '{7, 8, 0}, '{8, 9, 1},
    '{12, 2, 0}, '{13, 3, 0}, '{14, 5, 0}, '{15, 4, 0}, '{16, 6, 1}, '{17, 7, 1}
  };
  // {opcode, zero, taken}
  int br_tab [0:5][0:2] = '{
    '{10, 0, 1}, '{10, 1, 0}, '{9, 1, 1}, '{9, 0, 0}, '{11, 0, 1}, '{11, 1, 1}
  };

  control_fsm #(.WIDTH_OPCODE(5), .ALUOP_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .wb_sel(wb_sel), .state(state), .retired(retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] st, input logic ir, pw, ps, mr, mw, io, rw, sb,
                              input logic [3:0] aop, input logic wb, ret, ill);
    exp_t e;
    e = '{st: st, ir: ir, pw: pw, ps: ps, mr: mr, mw: mw, io: io, rw: rw, sb: sb,
          aop: aop, wb: wb, ret: ret, ill: ill};
    return e;
  endfunction

  function automatic exp_t f_fetch(input logic rdy);
    return mk(3'd0, rdy, rdy, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t f_dec(input logic ret);
    return mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, ret, 1'b0);
  endfunction
  function automatic exp_t f_exec(input logic [3:0] aop, input logic sb, pw, ret);
    return mk(3'd2, 1'b0, pw, pw, 1'b0, 1'b0, 1'b0, 1'b0, sb, aop, 1'b0, ret, 1'b0);
  endfunction
  function automatic exp_t f_mem(input logic mr, mw, ret);
    return mk(3'd3, 1'b0, 1'b0, 1'b0, mr, mw, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, ret, 1'b0);
  endfunction
  function automatic exp_t f_wb(input logic wb);
    return mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, wb, 1'b1, 1'b0);
  endfunction
  function automatic exp_t f_trap();
    return mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endfunction

  // Inputs are already applied for this cycle; queue the expectation and move to the next cycle
  task automatic cyc(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic run_stim();
    // Reset held: FETCH, no fetch progress, flags clear
    cyc("reset_hold", f_fetch(1'b0));
    reset = 1'b0;

    // ADD with mem_ready tied high: 0,1,2,4 then back to 0
    opcode = 5'd3; mem_ready = 1'b1;
    cyc("add_fetch", f_fetch(1'b1));
    cyc("add_decode", f_dec(1'b0));
    cyc("add_exec", f_exec(4'd0, 1'b0, 1'b0, 1'b0));
    cyc("add_wb", f_wb(1'b0));

    // Every ALU-class opcode
    for (int i = 0; i < 12; i++) begin
      opcode = 5'(alu_tab[i][0]);
      cyc($sformatf("alu%0d_fetch", alu_tab[i][0]), f_fetch(1'b1));
      cyc($sformatf("alu%0d_decode", alu_tab[i][0]), f_dec(1'b0));
      cyc($sformatf("alu%0d_exec", alu_tab[i][0]),
          f_exec(4'(alu_tab[i][1]), 1'(alu_tab[i][2]), 1'b0, 1'b0));
      cyc($sformatf("alu%0d_wb", alu_tab[i][0]), f_wb(1'b0));
    end

    // LR with three wait cycles in MEM; mem_ready high in DECODE/EXEC is ignored
    opcode = 5'd1; mem_ready = 1'b1;
    cyc("lr_fetch", f_fetch(1'b1));
    cyc("lr_decode", f_dec(1'b0));
    cyc("lr_exec", f_exec(4'd0, 1'b1, 1'b0, 1'b0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("lr_mem_wait%0d", i), f_mem(1'b1, 1'b0, 1'b0));
    mem_ready = 1'b1;
    cyc("lr_mem_done", f_mem(1'b1, 1'b0, 1'b0));
    cyc("lr_wb", f_wb(1'b1));

    // SR, no wait: retires out of MEM
    opcode = 5'd2;
    cyc("sr_fetch", f_fetch(1'b1));
    cyc("sr_decode", f_dec(1'b0));
    cyc("sr_exec", f_exec(4'd0, 1'b1, 1'b0, 1'b0));
    cyc("sr_mem", f_mem(1'b0, 1'b1, 1'b1));

    // Branches: taken/not-taken by zero flag
    for (int i = 0; i < 6; i++) begin
      opcode = 5'(br_tab[i][0]);
      zero   = 1'(br_tab[i][1]);
      cyc($sformatf("br%0d_z%0d_fetch", br_tab[i][0], br_tab[i][1]), f_fetch(1'b1));
      cyc($sformatf("br%0d_z%0d_decode", br_tab[i][0], br_tab[i][1]), f_dec(1'b0));
      cyc($sformatf("br%0d_z%0d_exec", br_tab[i][0], br_tab[i][1]),
          f_exec(4'd1, 1'b0, 1'(br_tab[i][2]), 1'b1));
    end
    zero = 1'b0;

    // NOP preceded by a stalled fetch
    opcode = 5'd0; mem_ready = 1'b0;
    cyc("nop_fetch_stall0", f_fetch(1'b0));
    cyc("nop_fetch_stall1", f_fetch(1'b0));
    mem_ready = 1'b1;
    cyc("nop_fetch", f_fetch(1'b1));
    cyc("nop_decode", f_dec(1'b1));

    // Illegal opcode 0x14
    opcode = 5'h14;
    cyc("ill_fetch", f_fetch(1'b1));
`ifdef ILLEGAL_TRAP_EN
    cyc("ill_decode", f_dec(1'b0));
    for (int i = 0; i < 10; i++) cyc($sformatf("ill_trap%0d", i), f_trap());
`else
    cyc("ill_decode", f_dec(1'b1));
    cyc("ill_next_fetch", f_fetch(1'b1));
`endif

    // Reset from wherever we are, then reset in the middle of an SR wait
    mem_ready = 1'b0; reset = 1'b1;
    cyc("reset_pre", f_fetch(1'b0));
    reset = 1'b0; opcode = 5'd2; mem_ready = 1'b1;
    cyc("sr2_fetch", f_fetch(1'b1));
    cyc("sr2_decode", f_dec(1'b0));
    cyc("sr2_exec", f_exec(4'd0, 1'b1, 1'b0, 1'b0));
    mem_ready = 1'b0;
    cyc("sr2_mem_wait0", f_mem(1'b0, 1'b1, 1'b0));
    reset = 1'b1;
    cyc("reset_mid_mem", f_fetch(1'b0));
    cyc("reset_mid_mem_hold", f_fetch(1'b0));
    reset = 1'b0; opcode = 5'd0; mem_ready = 1'b1;
    cyc("post_reset_fetch", f_fetch(1'b1));
    cyc("post_reset_decode", f_dec(1'b1));

    repeat (2) @(posedge clk);
  endtask

  initial begin
    exp_t  e;
    exp_t  act;
    string nm;
    reset = 1'b1; opcode = 5'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    fork
      begin
        forever begin
          @(negedge clk);
          if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {state, ir_write, pc_write, pc_src, mem_read, mem_write, iord, reg_write,
                   alu_src_b, alu_op, wb_sel, retired, illegal};
            n_assert++;
            if (act !== e) begin
              n_fail++;
              $display("FAIL %s: got st=%0d ir/pw/ps/mr/mw/io/rw/sb=%b aop=%0d wb/ret/ill=%b, required st=%0d ir/pw/ps/mr/mw/io/rw/sb=%b aop=%0d wb/ret/ill=%b",
                       nm, act.st, {act.ir, act.pw, act.ps, act.mr, act.mw, act.io, act.rw, act.sb},
                       act.aop, {act.wb, act.ret, act.ill},
                       e.st, {e.ir, e.pw, e.ps, e.mr, e.mw, e.io, e.rw, e.sb},
                       e.aop, {e.wb, e.ret, e.ill});
            end
            n_assert++;
            if (mem_read && mem_write) begin
              n_fail++;
              $display("FAIL %s_mem_excl: got mem_read=%b mem_write=%b, required not both 1",
                       nm, mem_read, mem_write);
            end
          end
        end
      end
      begin
        run_stim();
      end
    join_any
    disable fork;
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
